// File: rtl/scaler_pkg.sv
// Shared constants and types for the horizontal video scaler.
package scaler_pkg;

    localparam int unsigned STEP_FRAC_W = 12;
    localparam int unsigned POS_INT_W   = 16;
    localparam int unsigned POS_W       = POS_INT_W + STEP_FRAC_W;
    localparam logic [15:0] STEP_MIN    = 16'd2048;
    localparam int unsigned OUT_LAT     = 3;
    localparam int unsigned SYNC_LAT    = 6;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_ACTIVE
    } state_t;

endpackage

// File: rtl/scaler_lerp.sv
// Three-stage 2-tap linear interpolator: window register, multiply, sum/shift.
// SCALER_H_ROUND_EN selects round-half-up instead of truncation.
module scaler_lerp
    import scaler_pkg::*;
#(
    parameter int unsigned COE_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] prev,
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic [COE_WIDTH-1:0]  coe,
    input  logic                  valid,
    output logic [DATA_WIDTH-1:0] pix,
    output logic                  pix_valid
);

    localparam int unsigned ACC_W = DATA_WIDTH + COE_WIDTH + 1;

    logic [DATA_WIDTH-1:0] prev_r;
    logic [DATA_WIDTH-1:0] cur_r;
    logic [COE_WIDTH-1:0]  coe_r;
    logic [ACC_W-1:0]      m_prev;
    logic [ACC_W-1:0]      m_cur;
    logic [ACC_W-1:0]      sum;
    logic [OUT_LAT-1:0]    v_pipe;

`ifdef SCALER_H_ROUND_EN
    assign sum = m_prev + m_cur + ACC_W'(32'd1 << (COE_WIDTH - 1));
`else
    assign sum = m_prev + m_cur;
`endif

    assign pix_valid = v_pipe[OUT_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r <= '0;
            cur_r  <= '0;
            coe_r  <= '0;
            m_prev <= '0;
            m_cur  <= '0;
            pix    <= '0;
            v_pipe <= '0;
        end else begin
            prev_r <= prev;
            cur_r  <= cur;
            coe_r  <= coe;
            m_prev <= ACC_W'(prev_r) * (ACC_W'(32'd1 << COE_WIDTH) - ACC_W'(coe_r));
            m_cur  <= ACC_W'(cur_r) * ACC_W'(coe_r);
            pix    <= DATA_WIDTH'(sum >> COE_WIDTH);
            v_pipe <= {v_pipe[OUT_LAT-2:0], valid};
        end
    end

endmodule

// File: rtl/video_scaler_h.sv
// Horizontal scaler: per-line 4.12 position stepping feeding a linear interpolator.
// Optional macro SCALER_H_ROUND_EN enables rounding in the interpolator.
module video_scaler_h
    import scaler_pkg::*;
#(
    parameter int unsigned PIXEL_STEP = 4096,
    parameter int unsigned COE_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           scale_step,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [15:0]           pix_count_o,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    state_t                state;
    pos_t                  pos;
    logic [15:0]           step_r;
    logic [15:0]           n;
    logic [15:0]           out_cnt;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] cur;
    logic [SYNC_LAT-1:0]   hs_pipe;
    logic [SYNC_LAT-1:0]   vs_pipe;

    logic [POS_INT_W-1:0]   pos_int;
    logic [STEP_FRAC_W-1:0] pos_frac;
    logic                   active_c;
    logic                   gen_c;
    logic                   edge_c;
    logic [DATA_WIDTH-1:0]  lerp_prev;
    logic [COE_WIDTH-1:0]   lerp_coe;

    assign pos_int  = pos[POS_W-1:STEP_FRAC_W];
    assign pos_frac = pos[STEP_FRAC_W-1:0];
    assign active_c = (state == S_ACTIVE) && !de_i;
    // Interior output: position lies between the two windowed pixels.
    assign gen_c    = active_c && (n >= 16'd2) && (pos_int == n - 16'd2);
    // Edge output: position lands exactly on the last pixel at line end.
    assign edge_c   = active_c && !gen_c && hs_i && (n != 16'd0)
                      && (pos_int == n - 16'd1) && (pos_frac == '0);

    assign lerp_prev = edge_c ? cur : prev;
    assign lerp_coe  = edge_c ? '0 : pos[STEP_FRAC_W-1 -: COE_WIDTH];

    assign hs_o = hs_pipe[SYNC_LAT-1];
    assign vs_o = vs_pipe[SYNC_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_WAIT;
            pos         <= '0;
            step_r      <= 16'(PIXEL_STEP);
            n           <= '0;
            out_cnt     <= '0;
            prev        <= '0;
            cur         <= '0;
            pix_count_o <= '0;
            hs_pipe     <= '1;
            vs_pipe     <= '1;
        end else begin
            hs_pipe <= {hs_pipe[SYNC_LAT-2:0], hs_i};
            vs_pipe <= {vs_pipe[SYNC_LAT-2:0], vs_i};
            if (hs_i) begin
                step_r <= (scale_step < STEP_MIN) ? STEP_MIN : scale_step;
            end
            if (de_i) begin
                prev <= cur;
                cur  <= di_i;
            end
            case (state)
                // After reset, ignore a partial line until blanking is seen.
                S_WAIT: begin
                    if (hs_i) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    pos     <= '0;
                    out_cnt <= '0;
                    n       <= '0;
                    if (!hs_i) begin
                        state <= S_ACTIVE;
                        n     <= de_i ? 16'd1 : 16'd0;
                    end
                end
                S_ACTIVE: begin
                    if (de_i) begin
                        n <= n + 16'd1;
                    end else if (gen_c || edge_c) begin
                        pos     <= pos + pos_t'(step_r);
                        out_cnt <= out_cnt + 16'd1;
                    end
                    if (hs_i && !de_i && !gen_c) begin
                        pix_count_o <= edge_c ? out_cnt + 16'd1 : out_cnt;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    scaler_lerp #(
        .COE_WIDTH (COE_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lerp (
        .clk      (clk),
        .rst      (rst),
        .prev     (lerp_prev),
        .cur      (cur),
        .coe      (lerp_coe),
        .valid    (gen_c || edge_c),
        .pix      (do_o),
        .pix_valid(de_o)
    );

endmodule

// File: tb/tb_video_scaler_h.sv
// Bench for video_scaler_h: reference-model scoreboard plus directed sync/reset checks.
module tb_video_scaler_h;

    localparam int unsigned COE = 10;
    localparam int unsigned DW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   scale_step;
    logic [DW-1:0] di_i;
    logic          de_i;
    logic          hs_i;
    logic          vs_i;
    logic [15:0]   pix_count_o;
    logic [DW-1:0] do_o;
    logic          de_o;
    logic          hs_o;
    logic          vs_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int got[$];
    int pix[64];
    bit sb_en = 1'b0;
    logic [5:0] hs_hist;
    logic [5:0] vs_hist;

    video_scaler_h #(
        .PIXEL_STEP(4096),
        .COE_WIDTH (COE),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scale_step (scale_step),
        .di_i       (di_i),
        .de_i       (de_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .pix_count_o(pix_count_o),
        .do_o       (do_o),
        .de_o       (de_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o)
    );

    always #5 clk = ~clk;

    // Independent 6-clock history of the sync inputs.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_hist <= '1;
            vs_hist <= '1;
        end else begin
            hs_hist <= {hs_hist[4:0], hs_i};
            vs_hist <= {vs_hist[4:0], vs_i};
        end
    end

    always @(negedge clk) begin
        int e;
        if (rst) begin
            total++;
            assert (hs_o === hs_hist[5] && vs_o === vs_hist[5]) else begin
                bad++;
                $error("FAIL sync obs=%b%b exp=%b%b", hs_o, vs_o, hs_hist[5], vs_hist[5]);
            end
            if (de_o) begin
                total++;
                assert (hs_o === 1'b0) else begin
                    bad++;
                    $error("FAIL de_in_blank obs=%b exp=0", hs_o);
                end
                if (sb_en) begin
                    got.push_back(int'(do_o));
                    total++;
                    assert (exp_q.size() > 0) else begin
                        bad++;
                        $error("FAIL sb_extra obs=%0d exp=none", do_o);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        total++;
                        assert (int'(do_o) === e) else begin
                            bad++;
                            $error("FAIL sb_pix obs=%0d exp=%0d", do_o, e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference: positions k*step up to the last pixel, 2-tap lerp on a 10-bit coefficient.
    function automatic void build_expect(input int w, input int step);
        int     s;
        longint p;
        int     i;
        int     f;
        int     c;
        int     v;
        s = (step < 2048) ? 2048 : step;
        p = 0;
        if (w == 0) return;
        while (p <= longint'(w - 1) * 4096) begin
            i = int'(p / 4096);
            f = int'(p % 4096);
            c = f >> (12 - COE);
            if (i == w - 1) begin
                v = pix[i];
            end else begin
                v = pix[i] * (1024 - c) + pix[i + 1] * c;
`ifdef SCALER_H_ROUND_EN
                v = v + 512;
`endif
                v = v >> COE;
            end
            exp_q.push_back(v);
            p = p + s;
        end
    endfunction

    task automatic send_pixels(input int w);
        for (int i = 0; i < w; i++) begin
            di_i = DW'(pix[i]);
            de_i = 1'b1;
            tick();
            de_i = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic run_line(input int w, input int step, input int exp_cnt, input string tag);
        scale_step = 16'(step);
        repeat (3) tick();
        build_expect(w, step);
        got.delete();
        hs_i = 1'b0;
        repeat (2) tick();
        send_pixels(w);
        hs_i = 1'b1;
        repeat (14) tick();
        chk({tag, "_cnt"}, int'(pix_count_o), exp_cnt);
        chk({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        scale_step = 16'd4096;
        di_i       = '0;
        de_i       = 1'b0;
        hs_i       = 1'b1;
        vs_i       = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("rst_do", int'(do_o), 0);
        chk("rst_de", int'(de_o), 0);
        chk("rst_hs", int'(hs_o), 1);
        chk("rst_vs", int'(vs_o), 1);
        chk("rst_cnt", int'(pix_count_o), 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        vs_i = 1'b0;
        repeat (8) tick();
        sb_en = 1'b1;

        for (int i = 0; i < 25; i++) pix[i] = i;
        run_line(25, 4096, 25, "unity");
        run_line(25, 8192, 13, "down2");

        vs_i = 1'b1;
        repeat (4) tick();
        vs_i = 1'b0;

        for (int i = 0; i < 25; i++) pix[i] = (i == 12) ? 255 : 0;
        run_line(25, 3686, 27, "delta");
        chk("delta_k13", (got.size() > 14) ? got[13] : -1, 178);
        chk("delta_k14", (got.size() > 14) ? got[14] : -1, 102);

        for (int i = 0; i < 25; i++) pix[i] = i;
        run_line(25, 1024, 49, "clamp");

        pix[0] = 77;
        run_line(1, 4096, 1, "w1");
        chk("w1_pix", (got.size() > 0) ? got[0] : -1, 77);
        run_line(0, 4096, 0, "w0");

        pix[0] = 0;
        pix[1] = 1;
        run_line(2, 2048, 3, "mid");
`ifdef SCALER_H_ROUND_EN
        chk("mid_round", (got.size() > 1) ? got[1] : -1, 1);
`else
        chk("mid_trunc", (got.size() > 1) ? got[1] : -1, 0);
`endif

        // Abort a line with reset; outputs must clear without waiting for a clock.
        for (int i = 0; i < 25; i++) pix[i] = 200 - i;
        run_line(25, 4096, 25, "pre_rst");
        sb_en = 1'b0;
        hs_i  = 1'b0;
        repeat (2) tick();
        send_pixels(5);
        rst  = 1'b0;
        hs_i = 1'b1;
        #1;
        chk("mid_rst_de", int'(de_o), 0);
        chk("mid_rst_cnt", int'(pix_count_o), 0);
        chk("mid_rst_hs", int'(hs_o), 1);
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        exp_q.delete();
        sb_en = 1'b1;
        for (int i = 0; i < 25; i++) pix[i] = 3 * i;
        run_line(25, 8192, 13, "post_rst");

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
